// File: rtl/ucie_serdes_pkg.sv
// Shared serializer/deserializer definitions: default frame width, counter
// sizing and the IDLE/SHIFT state type used on both sides of the link.
package ucie_serdes_pkg;

  localparam int SERDES_DATA_WIDTH = 64;

  // A one-bit frame still needs a legal (non-zero) counter width.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int SERDES_CNT_W = cnt_width(SERDES_DATA_WIDTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } serdes_state_e;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry valid/ready holding register feeding the serializer shifter.
// Ready depends only on the full flag, so there is no valid->ready path.
module ser_hold_reg
  import ucie_serdes_pkg::*;
#(
  parameter int DATA_WIDTH = SERDES_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  drain_i,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  full_q;
  logic                  full_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  // Capture needs an empty entry and drain needs a full one, so they never
  // compete for the same edge in a way that could lose a word.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (drain_i) begin
      full_d = 1'b0;
    end else if (in_valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else begin
      full_d = full_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready_o = ~full_q;
  assign full_o     = full_q;
  assign data_o     = data_q;

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial frame transmitter, LSB first. Frames run back to back
// whenever the holding register is refilled before the last bit goes out.
module serializer
  import ucie_serdes_pkg::*;
#(
  parameter int   DATA_WIDTH = SERDES_DATA_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  frame_done
);

  localparam int               CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  serdes_state_e         state_q;
  serdes_state_e         state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  load_s;
  logic                  hold_full_s;
  logic [DATA_WIDTH-1:0] hold_data_s;

  ser_hold_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk_i      (CLK),
    .rst_i      (RST),
    .in_data_i  (P_DATA),
    .in_valid_i (data_valid),
    .in_ready_o (data_ready),
    .drain_i    (load_s),
    .full_o     (hold_full_s),
    .data_o     (hold_data_s)
  );

  // A new word is loaded either from IDLE or straight on the last bit, which
  // is what keeps consecutive frames gap-free.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_s) begin
          load_s  = 1'b1;
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shift_d = hold_data_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          if (hold_full_s) begin
            load_s  = 1'b1;
            cnt_d   = '0;
            shift_d = hold_data_s;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            shift_d = '0;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = shift_q >> 1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Outputs decode flops only; the idle level masks the stale shifter bit.
  assign ser_valid  = (state_q == ST_SHIFT);
  assign ser_out    = ser_valid ? shift_q[0] : IDLE_LEVEL;
  assign frame_done = ser_valid && (cnt_q == LAST_CNT);

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: frame-level reference model checked
// every cycle, a behavioural deserializer, and hand-computed frame literals.
module tb_serializer;

  localparam int W = 64;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         data_valid;
  logic         data_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_done;

  serializer #(.DATA_WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  // Reference model: a word queue for the holding slot and the position of
  // the bit currently on the wire (-1 when idle).
  logic [W-1:0] m_hold[$];
  logic [W-1:0] m_acc_list[$];
  logic [W-1:0] m_cur;
  int           m_pos = -1;
  int           m_acc_cnt = 0;
  bit           m_acc;

  always @(posedge CLK) begin
    if (RST === 1'b1) begin
      m_hold.delete();
      m_pos = -1;
    end else begin
      m_acc = (data_valid === 1'b1) && (m_hold.size() == 0);
      if ((m_pos < 0 || m_pos == W - 1) && m_hold.size() > 0) begin
        m_cur = m_hold.pop_front();
        m_pos = 0;
      end else if (m_pos == W - 1) begin
        m_pos = -1;
      end else if (m_pos >= 0) begin
        m_pos++;
      end
      if (m_acc) begin
        m_hold.push_back(P_DATA);
        m_acc_list.push_back(P_DATA);
        m_acc_cnt++;
      end
    end
  end

  int           tests = 0;
  int           fails = 0;
  bit           chk_en = 1'b0;
  int           cyc = 0;
  int           n_valid = 0;
  int           n_ones = 0;
  int           n_rdy_low = 0;
  int           run = 0;
  logic [W-1:0] rx = '0;
  logic [W-1:0] rx_q[$];
  int           fd_t[$];
  int           fd_run[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model plus observation statistics.
  task automatic compare_loop();
    logic exp_v;
    logic exp_o;
    logic [W-1:0] rx_n;
    forever begin
      @(negedge CLK);
      cyc++;
      if (chk_en) begin
        exp_v = (m_pos >= 0);
        exp_o = exp_v ? m_cur[m_pos] : 1'b0;
        check("ser_valid", {63'd0, ser_valid}, {63'd0, exp_v});
        check("ser_out", {63'd0, ser_out}, {63'd0, exp_o});
        check("frame_done", {63'd0, frame_done}, {63'd0, (m_pos == W - 1)});
        check("data_ready", {63'd0, data_ready}, {63'd0, (m_hold.size() == 0)});
        if (data_ready === 1'b0) n_rdy_low++;
        if (ser_valid === 1'b1) begin
          n_valid++;
          run++;
          if (ser_out === 1'b1) n_ones++;
          rx_n = {ser_out, rx[W-1:1]};
          rx   = rx_n;
          if (frame_done === 1'b1) begin
            rx_q.push_back(rx_n);
            fd_t.push_back(cyc);
            fd_run.push_back(run);
          end
        end else begin
          run = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    data_valid = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Present a word and keep data_valid high until the model says it was taken.
  task automatic send(input logic [W-1:0] w);
    int start;
    start = m_acc_cnt;
    P_DATA = w;
    data_valid = 1'b1;
    for (int i = 0; i < 300 && m_acc_cnt == start; i++) tick();
    tests++;
    if (m_acc_cnt == start) begin
      fails++;
      $display("FAIL send_timeout: got no accept, expected accept of %h", w);
    end
  endtask

  int           b_valid;
  int           b_ones;
  int           b_rx;
  int           b_fd;
  int           b_acc;
  int           b_rdy;
  logic [W-1:0] w_tmp;

  task automatic mark();
    b_valid = n_valid;
    b_ones  = n_ones;
    b_rx    = rx_q.size();
    b_fd    = fd_t.size();
    b_acc   = m_acc_list.size();
    b_rdy   = n_rdy_low;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    P_DATA = '0;
    data_valid = 1'b0;
    RST = 1'b1;
    fork
      compare_loop();
    join_none

    // Reset state
    do_reset();
    check("rst_ready", {63'd0, data_ready}, 64'd1);
    check("rst_valid", {63'd0, ser_valid}, 64'd0);
    check("rst_ser_out", {63'd0, ser_out}, 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    chk_en = 1'b1;

    // Single word 1: one '1' bit, 64 valid cycles, one frame_done
    mark();
    send(64'h0000_0000_0000_0001);
    data_valid = 1'b0;
    repeat (80) tick();
    check("single_valid_cycles", 64'(n_valid - b_valid), 64'd64);
    check("single_ones", 64'(n_ones - b_ones), 64'd1);
    check("single_frames", 64'(rx_q.size() - b_rx), 64'd1);
    check("single_word", rx_q[b_rx], 64'h0000_0000_0000_0001);
    check("single_idle_out", {63'd0, ser_out}, 64'd0);

    // Back-to-back frames
    mark();
    send(64'hA5A5_A5A5_A5A5_A5A5);
    send(64'hFFFF_FFFF_0000_0000);
    data_valid = 1'b0;
    repeat (150) tick();
    check("b2b_valid_cycles", 64'(n_valid - b_valid), 64'd128);
    check("b2b_frames", 64'(fd_t.size() - b_fd), 64'd2);
    check("b2b_fd_spacing", 64'(fd_t[b_fd+1] - fd_t[b_fd]), 64'd64);
    check("b2b_contiguous", 64'(fd_run[b_fd+1]), 64'd128);
    check("b2b_word0", rx_q[b_rx], 64'hA5A5_A5A5_A5A5_A5A5);
    check("b2b_word1", rx_q[b_rx+1], 64'hFFFF_FFFF_0000_0000);

    // Backpressure: valid held high with a new word every cycle
    mark();
    for (int i = 0; i < 200; i++) begin
      P_DATA = {32'hC0DE_0000 | 32'(i), 32'(i) * 32'h9E37_79B9};
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    repeat (200) tick();
    check("bp_accepts", 64'(m_acc_list.size() - b_acc), 64'd5);
    check("bp_frames", 64'(rx_q.size() - b_rx), 64'd5);
    check("bp_ready_low_seen", 64'(n_rdy_low - b_rdy > 0), 64'd1);
    check("bp_word0", rx_q[b_rx], 64'hC0DE_0000_0000_0000);
    check("bp_word1", rx_q[b_rx+1], 64'hC0DE_0002_3C6E_F372);
    for (int k = 0; k < 5; k++) begin
      if (b_rx + k < rx_q.size()) begin
        w_tmp = m_acc_list[b_acc+k];
        check("bp_order", rx_q[b_rx+k], w_tmp);
      end
    end

    // Reset mid-frame with a held word pending
    send(64'h1111_2222_3333_4444);
    send(64'h5555_6666_7777_8888);
    data_valid = 1'b0;
    for (int i = 0; i < 300 && m_pos != 20; i++) tick();
    check("mid_reached_bit20", 64'(m_pos), 64'd20);
    check("mid_hold_pending", {63'd0, data_ready}, 64'd0);
    RST = 1'b1;
    data_valid = 1'b1;
    P_DATA = 64'h9999_9999_9999_9999;
    tick();
    RST = 1'b0;
    data_valid = 1'b0;
    check("mid_rst_valid", {63'd0, ser_valid}, 64'd0);
    check("mid_rst_ready", {63'd0, data_ready}, 64'd1);
    mark();
    repeat (150) tick();
    check("mid_no_bits", 64'(n_valid - b_valid), 64'd0);
    check("mid_no_frames", 64'(rx_q.size() - b_rx), 64'd0);

    // Loopback into a behavioural deserializer
    mark();
    send(64'hDEAD_BEEF_CAFE_F00D);
    data_valid = 1'b0;
    repeat (80) tick();
    check("loop_frames", 64'(rx_q.size() - b_rx), 64'd1);
    check("loop_word", rx_q[b_rx], 64'hDEAD_BEEF_CAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: parallel word width and bits per frame.
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b0: ser_out level whenever ser_valid is low.
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port P_DATA  in  DATA_WIDTH  parallel word to transmit.
REQ-006 SHALL have port data_valid  in  1  P_DATA is valid this cycle.
REQ-007 SHALL have port data_ready  out  1  holding register empty, word will be accepted.
REQ-008 SHALL have port ser_out  out  1  serial bit stream, LSB first; drives downstream sampled_bit.
REQ-009 SHALL have port ser_valid  out  1  ser_out carries a frame bit; drives downstream deser_en.
REQ-010 SHALL have port frame_done  out  1  one-cycle pulse coincident with the last bit of a frame.

Function
REQ-011 SHALL accept a word on a rising edge where data_valid and data_ready are both high; P_DATA is captured into a one-entry holding register.
REQ-012 SHALL drive data_ready = NOT hold_full, from registered state only (no combinational path from data_valid).
REQ-013 SHALL ignore P_DATA and data_valid while data_ready is low; P_DATA may change freely then.
REQ-014 SHALL implement FSM states IDLE and SHIFT; IDLE->SHIFT when hold_full; SHIFT->SHIFT at bit DATA_WIDTH-1 if hold_full; SHIFT->IDLE at bit DATA_WIDTH-1 if hold empty.
REQ-015 SHALL load the shift register from the holding register, clearing hold_full, on the edge of each IDLE->SHIFT or SHIFT->SHIFT-at-last-bit transition.
REQ-016 SHALL present bit k of a word on ser_out during the (k+1)th cycle after the load edge: latency accept edge N -> bit 0 valid after edge N+1, bit k after edge N+1+k.
REQ-017 SHALL use a bit counter of width clog2(DATA_WIDTH), reset to 0 on every load, incrementing once per SHIFT cycle, wrapping DATA_WIDTH-1 -> 0 only via load.
REQ-018 SHALL hold ser_valid high for exactly DATA_WIDTH consecutive cycles per frame, with no gap between back-to-back frames when hold is refilled before the last bit.
REQ-019 SHALL assert frame_done exactly in the cycle ser_out carries bit DATA_WIDTH-1.
REQ-020 SHALL drive ser_out = IDLE_LEVEL whenever ser_valid is low.
REQ-021 SHALL allow hold capture and hold drain on the same edge only when hold was full and draining; net result hold_full stays 0 (capture requires data_ready, i.e. hold empty beforehand).

Reset
REQ-022 SHALL, while RST is high at a rising edge, set: FSM IDLE, hold_full 0, counter 0, shift register 0, ser_valid 0, ser_out IDLE_LEVEL, frame_done 0, data_ready 1 after that edge.
REQ-023 SHALL, on RST mid-frame, discard the in-flight frame and held word; no partial frame resumes after RST deasserts.
REQ-024 SHALL not accept a word on an edge where RST is high, regardless of data_valid.

Structure
REQ-025 SHALL take DATA_WIDTH default, counter width, and the FSM state typedef (IDLE, SHIFT) from shared package ucie_serdes_pkg, also used by deserializer-side logic.
REQ-026 SHALL instantiate one sub-module ser_hold_reg (one-entry valid/ready holding register); shifter, counter and FSM stay in serializer.

Verification
REQ-027 Single word: RST 1 two cycles, then P_DATA=64'h0000_0000_0000_0001 valid one cycle at edge N -> ser_valid high edges N+1..N+64, ser_out 1 only in first bit cycle, frame_done in 64th cycle, then IDLE with ser_out=0.
REQ-028 Back-to-back: data_valid held high with words 64'hA5A5_..._A5A5 then 64'hFFFF_..._0000 -> 128 contiguous ser_valid cycles, LSB-first bit order exact, two frame_done pulses 64 cycles apart.
REQ-029 Backpressure: data_valid high continuously with changing P_DATA while hold full -> data_ready low, only words present on accepting edges are transmitted, none duplicated or lost.
REQ-030 Reset mid-frame: RST pulsed at bit 20 of a frame with a held word pending -> ser_valid 0, data_ready 1 the next cycle; no further bits of either word appear.
REQ-031 Loopback: serializer ser_out/ser_valid into deserializer sampled_bit/deser_en, random 64-bit word 64'hDEAD_BEEF_CAFE_F00D -> deserializer P_DATA equals the word after frame_done.
